// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient controller: widths, FSM encoding and
// the coefficient bank layout.
package fir_pkg;

  localparam int NB    = 12;
  localparam int NTAPS = 9;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_e;

  // Index 0 is B0; packed so a whole bank moves in one assignment.
  typedef logic [NTAPS-1:0][NB-1:0] coef_bank_t;

endpackage

// File: rtl/fir_coef_ctrl_if.sv
// Sample stream and configuration bus between the source/host and the
// coefficient controller.
interface fir_coef_ctrl_if;
  import fir_pkg::*;

  logic [NB-1:0] UP_DIN;
  logic          UP_VIN;
  logic          UP_RDY;
  logic [NB-1:0] DIN;
  logic          VIN;
  logic          FIR_VOUT;
  logic          CFG_WE;
  logic [3:0]    CFG_ADDR;
  logic [NB-1:0] CFG_DATA;
  logic          CFG_COMMIT;
  logic          CFG_BUSY;
  logic          SWAP_DONE;
  logic          ERR;

  modport master (
    output UP_DIN, UP_VIN, FIR_VOUT, CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
    input  UP_RDY, DIN, VIN, CFG_BUSY, SWAP_DONE, ERR
  );

  modport slave (
    input  UP_DIN, UP_VIN, FIR_VOUT, CFG_WE, CFG_ADDR, CFG_DATA, CFG_COMMIT,
    output UP_RDY, DIN, VIN, CFG_BUSY, SWAP_DONE, ERR
  );

endinterface

// File: rtl/fir_inflight_cnt.sv
// Saturating up/down count of samples issued to the filter but not yet
// retired; flags any attempt to step outside [0, 2^CNT_W-1].
module fir_inflight_cnt #(
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic RST,
  input  logic inc_i,
  input  logic dec_i,
  output logic zero_o,
  output logic err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_q == CNT_MAX) err_o = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == '0) err_o = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fir_coef_ctrl.sv
// Shadow/active coefficient banks for myfir: stalls the sample stream on
// commit, drains in-flight samples, then swaps all taps in one cycle.
module fir_coef_ctrl
  import fir_pkg::*;
#(
  parameter int CNT_W    = 5,
  parameter int DRAIN_TO = 255
) (
  input  logic           clk,
  input  logic           RST,
  fir_coef_ctrl_if.slave bus,
  output logic [NB-1:0]  B0,
  output logic [NB-1:0]  B1,
  output logic [NB-1:0]  B2,
  output logic [NB-1:0]  B3,
  output logic [NB-1:0]  B4,
  output logic [NB-1:0]  B5,
  output logic [NB-1:0]  B6,
  output logic [NB-1:0]  B7,
  output logic [NB-1:0]  B8
);

  localparam int TO_W = $clog2(DRAIN_TO + 1);

  state_e          state_q, state_d;
  coef_bank_t      shadow_q, shadow_d;
  coef_bank_t      bank_q, bank_d;
  logic [NB-1:0]   din_q, din_d;
  logic            vin_q, vin_d;
  logic            up_rdy_q, up_rdy_d;
  logic            busy_q, busy_d;
  logic            swap_done_q, swap_done_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            cnt_zero;
  logic            cnt_err;
  logic            busy;

  fir_inflight_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .RST    (RST),
    .inc_i  (vin_q),
    .dec_i  (bus.FIR_VOUT),
    .zero_o (cnt_zero),
    .err_o  (cnt_err)
  );

  assign busy = (state_q != ST_RUN);

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bank_d      = bank_q;
    din_d       = din_q;
    vin_d       = 1'b0;
    to_d        = to_q;
    swap_done_d = 1'b0;
    err_d       = err_q | cnt_err;

    // A write in the commit cycle lands before the bank is copied in DRAIN.
    if (bus.CFG_WE) begin
      if (busy || bus.CFG_ADDR >= 4'(NTAPS)) err_d = 1'b1;
      else                                   shadow_d[bus.CFG_ADDR] = bus.CFG_DATA;
    end

    case (state_q)
      ST_RUN: begin
        din_d = bus.UP_DIN;
        vin_d = bus.UP_VIN;
        if (bus.CFG_COMMIT) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.CFG_COMMIT) err_d = 1'b1;
        to_d = to_q + TO_W'(1);
        // A sample issued last RUN cycle is not yet in the counter, so wait for it too.
        if (cnt_zero && !vin_q) begin
          state_d = ST_SWAP;
        end else if (to_q == TO_W'(DRAIN_TO)) begin
          state_d = ST_SWAP;
          err_d   = 1'b1;
        end
        if (state_d == ST_SWAP) begin
          bank_d      = shadow_q;
          swap_done_d = 1'b1;
        end
      end
      ST_SWAP: begin
        if (bus.CFG_COMMIT) err_d = 1'b1;
        to_d    = '0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    up_rdy_d = (state_d == ST_RUN);
    busy_d   = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= ST_RUN;
      // NOTE: both coefficient banks are reset because the filter must start from zero taps.
      shadow_q    <= '0;
      bank_q      <= '0;
      din_q       <= '0;
      vin_q       <= 1'b0;
      up_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
      swap_done_q <= 1'b0;
      err_q       <= 1'b0;
      to_q        <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bank_q      <= bank_d;
      din_q       <= din_d;
      vin_q       <= vin_d;
      up_rdy_q    <= up_rdy_d;
      busy_q      <= busy_d;
      swap_done_q <= swap_done_d;
      err_q       <= err_d;
      to_q        <= to_d;
    end
  end

  assign bus.UP_RDY    = up_rdy_q;
  assign bus.DIN       = din_q;
  assign bus.VIN       = vin_q;
  assign bus.CFG_BUSY  = busy_q;
  assign bus.SWAP_DONE = swap_done_q;
  assign bus.ERR       = err_q;

  assign B0 = bank_q[0];
  assign B1 = bank_q[1];
  assign B2 = bank_q[2];
  assign B3 = bank_q[3];
  assign B4 = bank_q[4];
  assign B5 = bank_q[5];
  assign B6 = bank_q[6];
  assign B7 = bank_q[7];
  assign B8 = bank_q[8];

endmodule
